// File: rtl/rtcl_p3s7_hs_dphy_send.sv
// rtl/rtcl_p3s7_hs_dphy_send.sv - AXI4-Stream raw pixel line to D-PHY HS lane word packer
module rtcl_p3s7_hs_dphy_send #(
  parameter int    DPHY_LANES = 2,
  parameter int    RAW_BITS   = 10,
  parameter int    GAP_CYCLES = 4,
  parameter string DEBUG      = "false"
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [DPHY_LANES-1:0][7:0] header_data,
  input  logic                       s_axi4s_tuser,
  input  logic                       s_axi4s_tlast,
  input  logic [RAW_BITS-1:0]        s_axi4s_tdata,
  input  logic                       s_axi4s_tvalid,
  output logic                       s_axi4s_tready,
  output logic                       dphy_request,
  output logic [DPHY_LANES-1:0][7:0] dphy_data,
  output logic                       dphy_valid,
  output logic                       busy
);

  // Lane word width, bit buffer width (worst case: W-1 leftover bits plus one pixel)
  localparam int W  = 8 * DPHY_LANES;
  localparam int BW = W + RAW_BITS - 1;
  localparam int FW = $clog2(BW + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_FLUSH,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bits_q, bits_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [W-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          req_q, req_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic          emit;
  logic [FW-1:0] fill_emit;
  logic [BW-1:0] bits_emit;
  logic [W-1:0]  hdr_word;
  logic [W-1:0]  flush_word;

  // Next-state, bit-buffer packing and registered-output values
  always_comb begin
    state_d   = state_q;
    bits_d    = bits_q;
    fill_d    = fill_q;
    gap_d     = gap_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    accept    = 1'b0;
    emit      = 1'b0;
    fill_emit = fill_q;
    bits_emit = bits_q;

    // Header word carries frame start in lane0 bit0, peeked from the pending first pixel
    hdr_word    = header_data;
    hdr_word[0] = s_axi4s_tuser;

    // Final partial word: anything at or above fill is padding and must read as zero
    for (int i = 0; i < W; i++) begin
      flush_word[i] = bits_q[i] & (FW'(i) < fill_q);
    end

    case (state_q)
      S_IDLE: begin
        if (s_axi4s_tvalid) begin
          state_d = S_HEADER;
          data_d  = hdr_word;
          valid_d = 1'b1;
          bits_d  = '0;
          fill_d  = '0;
        end
      end

      S_HEADER: begin
        state_d = S_PAYLOAD;
      end

      S_PAYLOAD: begin
        accept = s_axi4s_tvalid & ready_q;
        emit   = (fill_q >= FW'(W));
        if (emit) begin
          data_d    = bits_q[W-1:0];
          valid_d   = 1'b1;
          fill_emit = fill_q - FW'(W);
          bits_emit = bits_q >> W;
        end
        bits_d = bits_emit;
        fill_d = fill_emit;
        // New pixel lands directly above whatever survives this cycle's emit
        if (accept) begin
          bits_d = bits_emit | (BW'(s_axi4s_tdata) << fill_emit);
          fill_d = fill_emit + FW'(RAW_BITS);
          if (s_axi4s_tlast) begin
            state_d = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        if (fill_q == '0) begin
          state_d = S_GAP;
          gap_d   = '0;
        end else begin
          data_d  = flush_word;
          valid_d = 1'b1;
          bits_d  = bits_q >> W;
          fill_d  = (fill_q > FW'(W)) ? (fill_q - FW'(W)) : '0;
        end
      end

      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_d   = (state_d == S_HEADER) || (state_d == S_PAYLOAD) || (state_d == S_FLUSH);
    ready_d = (state_d == S_PAYLOAD);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; reset discards any partial packet
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      bits_q  <= '0;
      fill_q  <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      fill_q  <= fill_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign s_axi4s_tready = ready_q;
  assign dphy_request   = req_q;
  assign dphy_data      = data_q;
  assign dphy_valid     = valid_q;
  assign busy           = busy_q;

  // Debug builds expose the FSM state to an on-chip logic analyser; no functional effect
  if (DEBUG == "true") begin : g_debug
    (* mark_debug = "true", keep = "true" *) logic [2:0] dbg_state;
    assign dbg_state = state_q;
  end

endmodule

// File: tb/tb_rtcl_p3s7_hs_dphy_send.sv
// tb/tb_rtcl_p3s7_hs_dphy_send.sv - self-checking bench for the HS D-PHY line packer
module tb_rtcl_p3s7_hs_dphy_send;

  localparam int LANES = 2;
  localparam int W     = 8 * LANES;
  localparam int RB    = 10;
  localparam int GAP   = 4;

  logic                  aclk = 1'b0;
  logic                  aresetn;
  logic [LANES-1:0][7:0] header_data;
  logic                  tuser;
  logic                  tlast;
  logic [RB-1:0]         tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  dreq;
  logic [LANES-1:0][7:0] ddata;
  logic                  dvalid;
  logic                  busy;

  rtcl_p3s7_hs_dphy_send #(
    .DPHY_LANES (LANES),
    .RAW_BITS   (RB),
    .GAP_CYCLES (GAP),
    .DEBUG      ("false")
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .header_data    (header_data),
    .s_axi4s_tuser  (tuser),
    .s_axi4s_tlast  (tlast),
    .s_axi4s_tdata  (tdata),
    .s_axi4s_tvalid (tvalid),
    .s_axi4s_tready (tready),
    .dphy_request   (dreq),
    .dphy_data      (ddata),
    .dphy_valid     (dvalid),
    .busy           (busy)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  exp_q[$];
  int            cnt_q[$];
  logic [RB-1:0] pix[$];
  logic [W-1:0]  mw[$];
  bit            b2b_expect = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Reference packing: header, then the line as one LSB-first bitstream cut into W-bit words
  task automatic model_line(input logic [W-1:0] hdr, input bit fs);
    bit           bits[$];
    logic [W-1:0] w;
    mw.delete();
    w    = hdr;
    w[0] = fs;
    mw.push_back(w);
    foreach (pix[i]) begin
      for (int b = 0; b < RB; b++) bits.push_back(pix[i][b]);
    end
    while (bits.size() > 0) begin
      w = '0;
      for (int i = 0; i < W; i++) begin
        if (bits.size() > 0) w[i] = bits.pop_front();
      end
      mw.push_back(w);
    end
  endtask

  // Compare process: every valid word, request window word counts, header spacing, tready rules
  bit prev_req    = 1'b0;
  bit have_fall   = 1'b0;
  int cyc         = 0;
  int fall_cyc    = 0;
  int words_in_pk = 0;

  always @(negedge aclk) begin
    cyc++;
    if (!aresetn) begin
      prev_req    = 1'b0;
      have_fall   = 1'b0;
      words_in_pk = 0;
    end else begin
      if (dreq && !prev_req) begin
        words_in_pk = 0;
        chk("tready_at_header", tready, 0);
        chk("header_valid", dvalid, 1);
        if (have_fall) begin
          if (b2b_expect) begin
            chk("b2b_header_spacing", cyc - fall_cyc, GAP + 1);
          end else begin
            checks++;
            if (cyc - fall_cyc < GAP + 1) begin
              errors++;
              $display("FAIL header_spacing: got %0d cycles, want >= %0d", cyc - fall_cyc, GAP + 1);
            end
          end
        end
      end
      if (dvalid) begin
        chk("valid_inside_request", dreq, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h, want no word", ddata);
        end else begin
          chk("lane_word", ddata, exp_q.pop_front());
          words_in_pk++;
        end
      end
      if (!dreq && prev_req) begin
        if (cnt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL packet_count: got unexpected packet, want none");
        end else begin
          chk("packet_word_count", words_in_pk, cnt_q.pop_front());
        end
        fall_cyc  = cyc;
        have_fall = 1'b1;
      end
      if (!dreq) chk("tready_outside_request", tready, 0);
      else       chk("busy_in_request", busy, 1);
      prev_req = dreq;
    end
  end

  task automatic do_reset();
    aresetn = 1'b0;
    tvalid  = 1'b0;
    exp_q.delete();
    cnt_q.delete();
    @(negedge aclk);
    chk("rst_request", dreq, 0);
    chk("rst_valid", dvalid, 0);
    chk("rst_data", ddata, 0);
    chk("rst_tready", tready, 0);
    chk("rst_busy", busy, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic send_line(input logic [W-1:0] hdr, input bit fs, input bit bubbles,
                           input bit hold, input int abort_at);
    int idx    = 0;
    int budget = 0;
    bit hs;
    model_line(hdr, fs);
    foreach (mw[i]) exp_q.push_back(mw[i]);
    cnt_q.push_back(mw.size());
    header_data = hdr;
    while (idx < pix.size()) begin
      tdata  = pix[idx];
      tlast  = (idx == pix.size() - 1);
      tuser  = (idx == 0) ? fs : ~fs;
      tvalid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge aclk);
      hs = tvalid && tready;
      @(posedge aclk);
      #1;
      if (hs) idx++;
      if (abort_at >= 0 && idx == abort_at) begin
        do_reset();
        return;
      end
      budget++;
      if (budget > 300) begin
        checks++;
        errors++;
        $display("FAIL line_accept_timeout: got %0d of %0d pixels, want all", idx, pix.size());
        break;
      end
    end
    if (!hold) tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: got busy=1, want 0");
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    aresetn     = 1'b1;
    tvalid      = 1'b1;
    tuser       = 1'b0;
    tlast       = 1'b0;
    tdata       = '0;
    header_data = '0;
    @(posedge aclk);
    #1;
    do_reset();
    repeat (2) begin
      @(negedge aclk);
      chk("idle_request", dreq, 0);
      chk("idle_valid", dvalid, 0);
      chk("idle_busy", busy, 0);
    end

    // Basic line, model pinned against hand-packed words
    pix.delete();
    pix.push_back(10'h3FF); pix.push_back(10'h000); pix.push_back(10'h155); pix.push_back(10'h2AA);
    model_line(16'h1234, 1'b1);
    chk("pin_basic_len", mw.size(), 4);
    chk("pin_basic_hdr", mw[0], 16'h1235);
    chk("pin_basic_w0", mw[1], 16'h03FF);
    chk("pin_basic_w1", mw[2], 16'h9550);
    chk("pin_basic_w2", mw[3], 16'h00AA);
    send_line(16'h1234, 1'b1, 1'b0, 1'b0, -1);
    n = 0;
    while (dreq && n < 50) begin
      @(negedge aclk);
      n++;
    end
    for (int i = 0; i < GAP; i++) begin
      chk("gap_request_low", dreq, 0);
      @(negedge aclk);
    end
    wait_idle();

    // Exact fit, frame start low
    pix.delete();
    for (int i = 0; i < 8; i++) pix.push_back(RB'(i * 73 + 5));
    model_line(16'hABCD, 1'b0);
    chk("pin_exact_len", mw.size(), 6);
    chk("pin_exact_hdr", mw[0], 16'hABCC);
    send_line(16'hABCD, 1'b0, 1'b0, 1'b0, -1);
    wait_idle();

    // Input bubbles with a padded tail
    pix.delete();
    for (int i = 0; i < 7; i++) pix.push_back(RB'($urandom));
    send_line(16'h5A5A, 1'b1, 1'b1, 1'b0, -1);
    wait_idle();

    // Back-to-back lines, including a one-pixel line
    pix.delete();
    for (int i = 0; i < 3; i++) pix.push_back(RB'(i * 211 + 17));
    send_line(16'h0F0F, 1'b1, 1'b0, 1'b1, -1);
    b2b_expect = 1'b1;
    pix.delete();
    pix.push_back(10'h2C3);
    send_line(16'hF0F0, 1'b0, 1'b0, 1'b1, -1);
    pix.delete();
    for (int i = 0; i < 5; i++) pix.push_back(RB'(1023 - i * 99));
    send_line(16'h7777, 1'b1, 1'b0, 1'b0, -1);
    wait_idle();
    b2b_expect = 1'b0;

    // Reset mid-packet, then a fresh line
    pix.delete();
    for (int i = 0; i < 8; i++) pix.push_back(RB'(10'h3FF));
    send_line(16'hFFFF, 1'b1, 1'b0, 1'b0, 3);
    pix.delete();
    for (int i = 0; i < 3; i++) pix.push_back(RB'(i + 1));
    send_line(16'h1000, 1'b0, 1'b0, 1'b0, -1);
    wait_idle();

    chk("exp_words_drained", exp_q.size(), 0);
    chk("exp_packets_drained", cnt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtcl_p3s7_hs_dphy_send.md
# rtcl_p3s7_hs_dphy_send

Packs a raw AXI4-Stream pixel stream into D-PHY HS lane words, one packet per image line. It is the transmit-side counterpart of the HS D-PHY receive path. It sits between the Spartan-7 image pipeline and the D-PHY TX PPI. Each packet carries a header word followed by tightly bit-packed pixels, zero-padded to a whole lane word, then an idle gap.

## Interface
Parameters:
- DPHY_LANES, 2, number of HS lanes; word width W = 8*DPHY_LANES; W must be ≥ RAW_BITS.
- RAW_BITS, 10, pixel width.
- GAP_CYCLES, 4, idle cycles (request low) between packets; must be ≥ 1.
- DEBUG, "false", debug attribute pass-through only.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - aclk, in, 1, clock.
  - aresetn, in, 1, asynchronous active-low reset.
- Header input:
  - header_data, in, [DPHY_LANES-1:0][7:0], header word contents; sampled on the IDLE→HEADER transition.
- Pixel input (s_axi4s):
  - s_axi4s_tuser, in, 1, frame start; valid on the first pixel of a line.
  - s_axi4s_tlast, in, 1, last pixel of the line.
  - s_axi4s_tdata, in, RAW_BITS, pixel.
  - s_axi4s_tvalid, in, 1, input valid.
  - s_axi4s_tready, out, 1, input ready.
- D-PHY output:
  - dphy_request, out, 1, HS request; high for the whole packet.
  - dphy_data, out, [DPHY_LANES-1:0][7:0], lane word; lane k = stream bits [8k+7:8k].
  - dphy_valid, out, 1, word strobe; high only inside the request window.
- Status:
  - busy, out, 1, state ≠ IDLE.

## Operation
- States: IDLE, HEADER, PAYLOAD, FLUSH, GAP.
- IDLE:
  - s_axi4s_tready=0.
  - When s_axi4s_tvalid=1, capture header_data and capture tuser of the pending pixel (peek, not consumed) as frame_start; go to HEADER.
- HEADER (1 cycle):
  - Emit the captured header word, with lane0 bit0 replaced by frame_start.
  - Go to PAYLOAD.
- PAYLOAD:
  - s_axi4s_tready=1 unconditionally.
  - Accepted pixels are appended LSB-first to a bit buffer of width W+RAW_BITS-1, tracked by counter fill.
  - Each cycle: if fill ≥ W, emit the low W bits and shift them out.
  - Emit and accept may occur in the same cycle: next fill = fill − W·emit + RAW_BITS·accept.
  - On accepting a pixel with tlast=1, go to FLUSH.
- FLUSH:
  - Each cycle with fill > 0, emit the low W bits; bits above fill are forced to 0.
  - fill ← max(fill−W, 0).
  - When fill == 0 at the start of a cycle, go to GAP.
- GAP:
  - dphy_request=0; count GAP_CYCLES cycles, then go to IDLE.
- tuser on pixels other than the first of a line is ignored.
- A line of one pixel is legal: HEADER, one PAYLOAD accept, then FLUSH.
- Reset (any time, including mid-packet): state=IDLE, fill=0, buffer cleared, gap counter=0. The partial packet is discarded and never resumed.

## Timing
- All outputs are registered.
- Reset values: dphy_request=0, dphy_valid=0, dphy_data=0, s_axi4s_tready=0, busy=0.
- Header latency: tvalid seen in IDLE at cycle n → header word on dphy_data with dphy_valid=1 and dphy_request=1 at cycle n+1.
- dphy_request:
  - Rises with the header word.
  - Stays high through HEADER, PAYLOAD and FLUSH.
  - Falls on the cycle after the last FLUSH word.
- dphy_valid may drop inside the request window when fill < W; dphy_data is don't-care but held when dphy_valid=0.
- Word latency: a word becomes visible one cycle after the cycle in which fill ≥ W.
- Throughput: one pixel per cycle in PAYLOAD; no input stall while W ≥ RAW_BITS.
- Minimum spacing between packet headers: GAP_CYCLES+1 cycles from request fall.

## Test plan
- Reset and idle:
  - Stimulus: assert aresetn=0 mid-stream, then release with tvalid=0.
  - Required: all outputs 0; busy=0.
- Basic line (W=16):
  - Stimulus: pixels 0x3FF, 0x000, 0x155, 0x2AA (tlast on the last), tuser=1 on the first, header_data=16'h1234.
  - Required: header 16'h1235, then payload words 16'h03FF, 16'h9550, 16'h00AA, then request low for 4 cycles.
- Exact fit:
  - Stimulus: 8 pixels (80 bits).
  - Required: exactly 5 payload words, no padding word.
  - Stimulus: tuser=0 on the first pixel.
  - Required: header lane0 bit0 = 0.
- Input bubbles:
  - Stimulus: random tvalid gaps within a line.
  - Required: dphy_request stays high; dphy_valid gaps are allowed; the packed bitstream is identical to the gap-free case.
- Back-to-back lines:
  - Stimulus: tvalid held high across tlast.
  - Required: the next header appears exactly GAP_CYCLES+1 cycles after request falls; tready=0 through GAP/IDLE/HEADER.
- Reset mid-packet:
  - Stimulus: assert aresetn during PAYLOAD, then send a new line.
  - Required: the new packet starts with a header; no stale bits from the aborted line.
